mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit for the multicycle datapath.
- Sits directly downstream of the A and B operand registers, alongside the ALU.
- Consumes the same B-register value the ALU operand-B select receives as its input-0 choice.
- Results go to the HI/LO registers read by mfhi/mflo. The control FSM issues a start pulse and waits for done.

---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 75 +++++++
 tb/tb_mult_div_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control FSM and the multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master (output start, op, op_a, op_b, input hi, lo, busy, done, div_zero);
  modport slave  (input start, op, op_a, op_b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / restoring divide on magnitudes, sign fixed up at the end
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  mult_div_unit_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t             state, state_n;
  logic               op_q, neg_lo, neg_hi, div_zero_q, is_dz;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0]   mag_b, hi_q, lo_q, abs_a, abs_b, div_r, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, div_t;
  logic               div_ge;
  logic [CW-1:0]      cnt;
  assign is_dz = bus.op && (bus.op_b == '0);
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  // next state: a divide by zero skips the iteration entirely
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (bus.start ? (is_dz ? DONE : CALC) : IDLE) :
              (state == CALC) ? ((cnt == '0) ? FIX : CALC) :
              (state == FIX)  ? DONE : IDLE;
  end
  // one iteration step: shift-add for mult, compare-subtract for div; acc holds {rem, quotient}
  always_comb begin
    abs_a   = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    abs_b   = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_t   = acc[2*WIDTH-1:WIDTH-1];
    div_ge  = div_t >= {1'b0, mag_b};
    div_r   = div_ge ? WIDTH'(div_t - {1'b0, mag_b}) : div_t[WIDTH-1:0];
    step    = op_q ? {div_r, acc[WIDTH-2:0], div_ge} : {mul_sum, acc[WIDTH-1:1]};
    prod    = neg_lo ? -acc : acc;
    fix_lo  = op_q ? (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
    fix_hi  = op_q ? (neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
  end
  // datapath: capture on accepted start, iterate in CALC, publish signed result in FIX
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_q       <= 1'b0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      div_zero_q <= 1'b0;
      acc        <= '0;
      mag_b      <= '0;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (state == IDLE && bus.start) begin
      op_q       <= bus.op;
      neg_lo     <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
      neg_hi     <= bus.op_a[WIDTH-1];
      div_zero_q <= is_dz;
      acc        <= {{WIDTH{1'b0}}, abs_a};
      mag_b      <= abs_b;
      cnt        <= CW'(WIDTH - 1);
    end else if (state == CALC) begin
      acc        <= step;
      cnt        <= cnt - CW'(1);
    end else if (state == FIX) begin
      hi_q       <= fix_hi;
      lo_q       <= fix_lo;
    end
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state == CALC) || (state == FIX);
  assign bus.done     = (state == DONE);
  assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, random ops against an arithmetic model, and multi-cycle corner sequences
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic        op;
    logic [31:0] a, b, eh, el;
    logic        edz;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!o) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = q[31:0];
    end
  endtask
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic dz,
                       output int edges, output int bcnt, output logic moved,
                       output logic busy_at_done, output logic extra);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.op = o;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 1'($urandom);
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    edges = 1;
    bcnt = 0;
    moved = 1'b0;
    while (!bus.done && edges < 100) begin
      if (bus.busy) bcnt++;
      if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    h = bus.hi;
    l = bus.lo;
    dz = bus.div_zero;
    busy_at_done = bus.busy;
    @(posedge clk);
    #1;
    extra = bus.done | bus.busy;
  endtask
  initial begin
    logic [31:0] h, l, mh, ml;
    logic dz, mdz, moved, bad, extra, o;
    logic [31:0] a, b;
    logic [31:0] corners[5];
    int edges, bcnt, n;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    tbl[0] = '{1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0};
    tbl[3] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[4] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    tbl[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0};
    tbl[6] = '{1'b1, 32'd10, 32'd0, 32'h4000_0000, 32'h0, 1'b1};
    tbl[7] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
    tbl[8] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0};
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("reset_flags", {61'h0, bus.busy, bus.done, bus.div_zero}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, h, l, dz, edges, bcnt, moved, bad, extra);
      chk($sformatf("vec%0d_hi", i), {32'h0, h}, {32'h0, tbl[i].eh});
      chk($sformatf("vec%0d_lo", i), {32'h0, l}, {32'h0, tbl[i].el});
      chk($sformatf("vec%0d_dz", i), {63'h0, dz}, {63'h0, tbl[i].edz});
      chk($sformatf("vec%0d_latency", i), 64'(edges), tbl[i].edz ? 64'd1 : 64'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), tbl[i].edz ? 64'd0 : 64'd33);
      chk($sformatf("vec%0d_stable", i), {61'h0, moved, bad, extra}, 64'h0);
    end
    mh = tbl[8].eh;
    ml = tbl[8].el;
    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      model(o, a, b, mh, ml, mdz);
      do_op(o, a, b, h, l, dz, edges, bcnt, moved, bad, extra);
      chk($sformatf("rnd%0d_%s_%h_%h", i, o ? "div" : "mul", a, b), {h, l}, {mh, ml});
      chk($sformatf("rnd%0d_dz", i), {63'h0, dz}, {63'h0, mdz});
    end
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, h, l, dz, edges, bcnt, moved, bad, extra);
    chk("preload_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.op_a = 32'd9;
    bus.op_b = 32'd11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midop_reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("midop_reset_flags", {61'h0, bus.busy, bus.done, bus.div_zero}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    do_op(1'b1, 32'd100, 32'd7, h, l, dz, edges, bcnt, moved, bad, extra);
    chk("after_reset_div", {h, l}, {32'd2, 32'd14});
    chk("after_reset_latency", 64'(edges), 64'd34);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.op_a = 32'd3;
    bus.op_b = 32'd5;
    n = 0;
    bad = 1'b0;
    for (int k = 1; k <= 105; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
      if (bus.done && bus.busy) bad = 1'b1;
    end
    bus.start = 1'b0;
    chk("held_start_done_count", 64'(n), 64'd3);
    chk("held_start_done_busy_overlap", {63'h0, bad}, 64'h0);
    chk("held_start_result", {bus.hi, bus.lo}, {32'd0, 32'd15});
    repeat (2) @(posedge clk);
    #1;
    chk("held_start_idle_after", {62'h0, bus.busy, bus.done}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
